// File: rtl/logic_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// logic_unit
//   Shared 8-bit bitwise logic function unit (purely combinational).
//   op[2:1] selects the base function, op[0] inverts the selected result:
//     000 AND   001 NAND   010 OR    011 NOR
//     100 XOR   101 XNOR   110 NOT A 111 A
//
// Ports
//   a, b  in  8  operands
//   op    in  3  opcode
//   y     out 8  result
// -----------------------------------------------------------------------------
module logic_unit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [7:0] y
);

    logic [7:0] base;

    always_comb begin
        base = 8'h00;
        case (op[2:1])
            2'b00:   base = a & b;
            2'b01:   base = a | b;
            2'b10:   base = a ^ b;
            default: base = ~a;
        endcase
        y = op[0] ? ~base : base;
    end

endmodule

// -----------------------------------------------------------------------------
// logic_arbiter
//   Round-robin arbiter/sequencer sharing one logic_unit between two
//   requesters. A granted request is executed in one cycle, its result is
//   registered and held, tagged with the requester id, until the consumer
//   takes it. One operation is in flight at a time.
//
//   state | meaning
//   IDLE  | arbitrate; grant at most one requester, latch its operands
//   EXEC  | latched operands drive the logic unit; result captured at end
//   HOLD  | res_vld high, result held stable until res_rdy
//
// Ports
//   clk         in   1      single clock, rising edge
//   rst         in   1      synchronous active-high reset
//   vld0/vld1   in   1      request valid per requester
//   rdy0/rdy1   out  1      request accepted (combinational, IDLE only)
//   a0/b0,a1/b1 in   8      operands per requester
//   op0/op1     in   3      opcode per requester
//   res_vld     out  1      result valid
//   res_rdy     in   1      result consumer ready
//   res_data    out  8      result value
//   res_id      out  1      requester that issued the result
//   busy        out  1      registered, high whenever state is not IDLE
//   ops_done    out  CNT_W  saturating count of delivered results
// -----------------------------------------------------------------------------
module logic_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld0,
    output logic             rdy0,
    input  logic [7:0]       a0,
    input  logic [7:0]       b0,
    input  logic [2:0]       op0,
    input  logic             vld1,
    output logic             rdy1,
    input  logic [7:0]       a1,
    input  logic [7:0]       b1,
    input  logic [2:0]       op1,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic [7:0]       res_data,
    output logic             res_id,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t     state;
    logic       ptr;       // requester favoured when both are valid
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [2:0] op_q;
    logic       id_q;
    logic       gnt0;
    logic       gnt1;
    logic [7:0] unit_y;

    // Grant is combinational so the requester sees rdy in the same cycle it
    // raises vld. It is forced low during reset so nothing is accepted on
    // the reset edge.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && state == IDLE) begin
            if (vld0 && vld1) begin
                gnt0 = ~ptr;
                gnt1 = ptr;
            end else begin
                gnt0 = vld0;
                gnt1 = vld1;
            end
        end
    end

    assign rdy0 = gnt0;
    assign rdy1 = gnt1;

    logic_unit u_logic_unit (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (unit_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            op_q     <= 3'b000;
            id_q     <= 1'b0;
            res_vld  <= 1'b0;
            res_data <= 8'h00;
            res_id   <= 1'b0;
            busy     <= 1'b0;
            ops_done <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        a_q   <= gnt1 ? a1  : a0;
                        b_q   <= gnt1 ? b1  : b0;
                        op_q  <= gnt1 ? op1 : op0;
                        id_q  <= gnt1;
                        // Loser of this grant is favoured next time.
                        ptr   <= gnt0;
                        state <= EXEC;
                        busy  <= 1'b1;
                    end
                end
                EXEC: begin
                    res_data <= unit_y;
                    res_id   <= id_q;
                    res_vld  <= 1'b1;
                    state    <= HOLD;
                    busy     <= 1'b1;
                end
                HOLD: begin
                    if (res_rdy) begin
                        res_vld <= 1'b0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                        if (ops_done != CNT_MAX) begin
                            ops_done <= ops_done + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    res_vld <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_arbiter.sv
`timescale 1ns/1ps
module tb_logic_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld0, vld1;
    logic [7:0]  a0, b0, a1, b1;
    logic [2:0]  op0, op1;
    logic        res_rdy;

    logic        rdy0, rdy1, res_vld, res_id, busy;
    logic [7:0]  res_data;
    logic [15:0] ops_done;

    logic        rdy0_s, rdy1_s, res_vld_s, res_id_s, busy_s;
    logic [7:0]  res_data_s;
    logic [1:0]  ops_done_s;

    int checks   = 0;
    int failures = 0;
    int exp_ops  = 0;

    logic [8:0] sb [$];   // {id, data}

    logic [7:0] sweep_exp [0:7] = '{8'hC0, 8'h3F, 8'hFC, 8'h03,
                                    8'h3C, 8'hC3, 8'h0F, 8'hF0};

    always #5 clk = ~clk;

    logic_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .vld0(vld0), .rdy0(rdy0), .a0(a0), .b0(b0), .op0(op0),
        .vld1(vld1), .rdy1(rdy1), .a1(a1), .b1(b1), .op1(op1),
        .res_vld(res_vld), .res_rdy(res_rdy), .res_data(res_data),
        .res_id(res_id), .busy(busy), .ops_done(ops_done)
    );

    logic_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .vld0(vld0), .rdy0(rdy0_s), .a0(a0), .b0(b0), .op0(op0),
        .vld1(vld1), .rdy1(rdy1_s), .a1(a1), .b1(b1), .op1(op1),
        .res_vld(res_vld_s), .res_rdy(res_rdy), .res_data(res_data_s),
        .res_id(res_id_s), .busy(busy_s), .ops_done(ops_done_s)
    );

    function automatic logic [7:0] model_fn(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op);
        case (op)
            3'd0:    return a & b;
            3'd1:    return ~(a & b);
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    // Drivers: inputs change at posedge+1, outputs sampled at posedge+2.
    task automatic do_reset();
        rst = 1'b1; vld0 = 1'b0; vld1 = 1'b0; res_rdy = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        exp_ops = 0;
    endtask

    task automatic send(input logic r, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [7:0] exp_data);
        int   n;
        logic got;
        if (r) begin vld1 = 1'b1; a1 = a; b1 = b; op1 = op; end
        else   begin vld0 = 1'b1; a0 = a; b0 = b; op0 = op; end
        #1;
        n = 0;
        got = r ? rdy1 : rdy0;
        while (!got && n < 20) begin
            @(posedge clk); #2;
            got = r ? rdy1 : rdy0;
            n++;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL send_accept req=%0d rdy=0 required=1", r);
        end else begin
            sb.push_back({r, exp_data});
        end
        @(posedge clk); #1;
        if (r) vld1 = 1'b0; else vld0 = 1'b0;
    endtask

    task automatic collect();
        int         n;
        logic [8:0] e;
        res_rdy = 1'b1;
        #1;
        n = 0;
        while (!res_vld && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        checks++;
        if (!res_vld) begin
            failures++;
            $display("FAIL collect_timeout res_vld=0 required=1");
        end else if (sb.size() == 0) begin
            failures++;
            $display("FAIL collect_unexpected res_data=%h res_id=%0d required=no result", res_data, res_id);
        end else begin
            e = sb.pop_front();
            if (res_data !== e[7:0] || res_id !== e[8]) begin
                failures++;
                $display("FAIL collect_result data=%h id=%0d required data=%h id=%0d",
                         res_data, res_id, e[7:0], e[8]);
            end
            exp_ops++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; vld0 = 1'b1; vld1 = 1'b1; res_rdy = 1'b1;
        a0 = 8'h00; b0 = 8'h00; op0 = 3'd0; a1 = 8'h00; b1 = 8'h00; op1 = 3'd0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        checks++;
        if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_rdy rdy0=%b rdy1=%b required 0 0", rdy0, rdy1);
        end
        checks++;
        if (res_vld !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags res_vld=%b busy=%b required 0 0", res_vld, busy);
        end
        checks++;
        if (res_data !== 8'h00 || res_id !== 1'b0) begin
            failures++;
            $display("FAIL reset_result res_data=%h res_id=%b required 00 0", res_data, res_id);
        end
        checks++;
        if (ops_done !== 16'd0 || ops_done_s !== 2'd0) begin
            failures++;
            $display("FAIL reset_ops ops_done=%0d sat=%0d required 0 0", ops_done, ops_done_s);
        end
        rst = 1'b0; vld0 = 1'b0; vld1 = 1'b0;
        sb.delete();
        exp_ops = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        vld0 = 1'b1; a0 = 8'hF0; b0 = 8'hCC; op0 = 3'b000;
        #1;
        checks++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin
            failures++;
            $display("FAIL single_rdy rdy0=%b rdy1=%b required 1 0", rdy0, rdy1);
        end
        sb.push_back({1'b0, 8'hC0});
        @(posedge clk); #1;
        vld0 = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || res_vld !== 1'b0) begin
            failures++;
            $display("FAIL single_exec busy=%b res_vld=%b required 1 0", busy, res_vld);
        end
        @(posedge clk); #1;
        checks++;
        if (res_vld !== 1'b1) begin
            failures++;
            $display("FAIL single_latency res_vld=%b required 1", res_vld);
        end
        collect();
        #1;
        checks++;
        if (ops_done !== 16'(exp_ops) || exp_ops != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_ops ops_done=%0d busy=%b required 1 0", ops_done, busy);
        end
    endtask

    task automatic test_opcode_sweep();
        for (int op = 0; op < 8; op++) begin
            send(1'b1, 8'hF0, 8'hCC, 3'(op), sweep_exp[op]);
            collect();
        end
    endtask

    task automatic test_both_valid();
        int   grants;
        int   n;
        logic exp_id;
        logic [8:0] e;
        do_reset();
        a0 = 8'h5A; b0 = 8'h0F; op0 = 3'd4;
        a1 = 8'h33; b1 = 8'hF0; op1 = 3'd2;
        vld0 = 1'b1; vld1 = 1'b1;
        grants = 0; n = 0; exp_id = 1'b0;
        while (grants < 4 && n < 40) begin
            #1;
            checks++;
            if (rdy0 === 1'b1 && rdy1 === 1'b1) begin
                failures++;
                $display("FAIL both_rdy_exclusive rdy0=1 rdy1=1 required not both");
            end
            if (rdy0 || rdy1) begin
                checks++;
                if (rdy1 !== exp_id) begin
                    failures++;
                    $display("FAIL both_grant_order grant=%0d required %0d", rdy1, exp_id);
                end
                sb.push_back(rdy1 ? {1'b1, model_fn(a1, b1, op1)} : {1'b0, model_fn(a0, b0, op0)});
                exp_id = ~exp_id;
                grants++;
            end
            if (res_vld && res_rdy) begin
                checks++;
                e = (sb.size() != 0) ? sb.pop_front() : 9'h1FF;
                if (res_data !== e[7:0] || res_id !== e[8]) begin
                    failures++;
                    $display("FAIL both_result data=%h id=%0d required data=%h id=%0d",
                             res_data, res_id, e[7:0], e[8]);
                end
                exp_ops++;
            end
            @(posedge clk); #1;
            n++;
        end
        vld0 = 1'b0; vld1 = 1'b0;
        checks++;
        if (grants != 4) begin
            failures++;
            $display("FAIL both_grant_count grants=%0d required 4", grants);
        end
        collect();
    endtask

    task automatic test_backpressure();
        res_rdy = 1'b0;
        send(1'b0, 8'hA5, 8'h3C, 3'd0, 8'h24);
        @(posedge clk); #1;
        vld1 = 1'b1; a1 = 8'h0F; b1 = 8'hFF; op1 = 3'd5;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (res_vld !== 1'b1 || res_data !== 8'h24 || rdy0 !== 1'b0 || rdy1 !== 1'b0
                || ops_done !== 16'(exp_ops)) begin
                failures++;
                $display("FAIL hold_cycle%0d res_vld=%b data=%h rdy=%b%b ops=%0d required 1 24 00 %0d",
                         i, res_vld, res_data, rdy0, rdy1, ops_done, exp_ops);
            end
            @(posedge clk); #1;
        end
        collect();
        #1;
        checks++;
        if (ops_done !== 16'(exp_ops) || busy !== 1'b0 || rdy1 !== 1'b1) begin
            failures++;
            $display("FAIL hold_release ops=%0d busy=%b rdy1=%b required %0d 0 1",
                     ops_done, busy, rdy1, exp_ops);
        end
        sb.push_back({1'b1, model_fn(8'h0F, 8'hFF, 3'd5)});
        @(posedge clk); #1;
        vld1 = 1'b0;
        collect();
    endtask

    task automatic test_reset_exec();
        send(1'b0, 8'h12, 8'h34, 3'd2, 8'h36);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (res_vld !== 1'b0 || busy !== 1'b0 || ops_done !== 16'd0 || ops_done_s !== 2'd0) begin
            failures++;
            $display("FAIL rst_exec res_vld=%b busy=%b ops=%0d sat=%0d required 0 0 0 0",
                     res_vld, busy, ops_done, ops_done_s);
        end
        sb.delete();
        exp_ops = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            checks++;
            if (res_vld !== 1'b0) begin
                failures++;
                $display("FAIL rst_no_result cycle%0d res_vld=%b required 0", i, res_vld);
            end
        end
        @(posedge clk); #1;
        a0 = 8'h81; b0 = 8'h18; op0 = 3'd4;
        a1 = 8'h77; b1 = 8'h00; op1 = 3'd6;
        vld0 = 1'b1; vld1 = 1'b1;
        #1;
        checks++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin
            failures++;
            $display("FAIL rst_ptr rdy0=%b rdy1=%b required 1 0", rdy0, rdy1);
        end
        sb.push_back({1'b0, model_fn(8'h81, 8'h18, 3'd4)});
        @(posedge clk); #1;
        vld0 = 1'b0; vld1 = 1'b0;
        collect();
    endtask

    task automatic test_saturation();
        logic [1:0] sat_exp [0:4] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(1'(i), 8'(8'h10 * i + 3), 8'h5C, 3'(i + 1),
                 model_fn(8'(8'h10 * i + 3), 8'h5C, 3'(i + 1)));
            collect();
            #1;
            checks++;
            if (ops_done_s !== sat_exp[i] || ops_done !== 16'(exp_ops)) begin
                failures++;
                $display("FAIL sat_op%0d sat=%0d ops=%0d required %0d %0d",
                         i, ops_done_s, ops_done, sat_exp[i], exp_ops);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_opcode_sweep();
        test_both_valid();
        test_backpressure();
        test_reset_exec();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
